aes_kat_bist: RTL and testbench

//  Synthesisable known-answer-test (KAT) sequencer for a pipelined AES-128 core.
//  On start it streams a parameterised table of (state, key) vectors into the core
//  at one per cycle, then compares each core output with its expected ciphertext.
//  It reports pass/fail, the first failing index and an error count.

---
 rtl/aes_kat_bist_if.sv | 29 ++
 rtl/aes_kat_bist.sv | 161 ++++++++++++++++
 tb/tb_aes_kat_bist.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_kat_bist_if.sv
// Host/core-side bus of the AES known-answer-test sequencer.
// The slave modport is the sequencer; the master modport is whoever starts runs
// and supplies the core result (the cipher top, or a bench).
interface aes_kat_bist_if #(
   parameter int DATA_W = 128,
   parameter int IDX_W  = 3,
   parameter int ERR_W  = 8
);
   logic              start;
   logic              start_n_stop;
   logic [DATA_W-1:0] core_state;
   logic [DATA_W-1:0] core_key;
   logic [DATA_W-1:0] core_out;
   logic              busy;
   logic              done;
   logic              pass;
   logic [IDX_W-1:0]  fail_index;
   logic [ERR_W-1:0]  err_count;

   modport master (
      output start, start_n_stop, core_out,
      input  core_state, core_key, busy, done, pass, fail_index, err_count
   );

   modport slave (
      input  start, start_n_stop, core_out,
      output core_state, core_key, busy, done, pass, fail_index, err_count
   );
endinterface

// File: rtl/aes_kat_bist.sv
// Known-answer-test sequencer for a pipelined AES-128 core.
// Streams a table of (state, key) vectors into the core at one per cycle, follows
// each with a {valid, idx} tag through a LATENCY+1 stage pipeline, and compares the
// core result against the expected ciphertext when the tag falls out the end.
module aes_kat_bist #(
   parameter int DATA_W       = 128,
   parameter int NUM_VEC      = 5,
   parameter int IDX_W        = 3,
   parameter int LATENCY      = 20,
   parameter logic [NUM_VEC*DATA_W-1:0] VEC_STATE = {
      128'h00000000000000000000000000000001,
      128'h00000000000000000000000000000000,
      128'h00000000000000000000000000000000,
      128'h00112233445566778899aabbccddeeff,
      128'h3243f6a8885a308d313198a2e0370734},
   parameter logic [NUM_VEC*DATA_W-1:0] VEC_KEY = {
      128'h00000000000000000000000000000000,
      128'h00000000000000000000000000000001,
      128'h00000000000000000000000000000000,
      128'h000102030405060708090a0b0c0d0e0f,
      128'h2b7e151628aed2a6abf7158809cf4f3c},
   parameter logic [NUM_VEC*DATA_W-1:0] VEC_EXP = {
      128'h58e2fccefa7e3061367f1d57a4e7455a,
      128'h0545aad56da2a97c3663d1432a3d1c84,
      128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
      128'h69c4e0d86a7b0430d8cdb78070b4c55a,
      128'h3925841d02dc09fbdc118597196a0b32},
   parameter bit STOP_ON_FAIL = 1'b0,
   parameter bit CONTINUOUS   = 1'b0,
   parameter int ERR_W        = 8
) (
   input  logic           clk,
   input  logic           rst,
   aes_kat_bist_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

   state_t                       state_q, state_d;
   logic [IDX_W-1:0]             issue_idx_q, issue_idx_d;
   logic [DATA_W-1:0]            core_state_q, core_state_d;
   logic [DATA_W-1:0]            core_key_q, core_key_d;
   logic [LATENCY:0]             tag_vld_q, tag_vld_d;
   logic [LATENCY:0][IDX_W-1:0]  tag_idx_q, tag_idx_d;
   logic                         busy_q, busy_d;
   logic                         done_q, done_d;
   logic                         pass_q, pass_d;
   logic [IDX_W-1:0]             fail_index_q, fail_index_d;
   logic [ERR_W-1:0]             err_count_q, err_count_d;

   logic                         cmp_vld;
   logic [IDX_W-1:0]             cmp_idx;
   logic                         mismatch;
   logic                         restart;
   logic                         issue_now;

   // Oldest tag meets the core result; case inequality so an X/Z result counts as a miss
   always_comb begin
      cmp_vld  = tag_vld_q[LATENCY];
      cmp_idx  = tag_idx_q[LATENCY];
      mismatch = cmp_vld && (bus.core_out !== VEC_EXP[32'(cmp_idx)*DATA_W +: DATA_W]);
   end

   // Sequencer: next state, which entry (if any) is driven after this edge
   always_comb begin
      state_d     = state_q;
      issue_idx_d = issue_idx_q;
      restart     = 1'b0;
      issue_now   = 1'b0;
      case (state_q)
         IDLE:  restart = bus.start;
         DONE:  restart = bus.start || (CONTINUOUS && bus.start_n_stop);
         ISSUE: begin
            if (STOP_ON_FAIL && mismatch)      state_d = DRAIN;
            else if (issue_idx_q == LAST_IDX)  state_d = DRAIN;
            else begin
               issue_now   = 1'b1;
               issue_idx_d = issue_idx_q + 1'b1;
            end
         end
         DRAIN: if (!(|tag_vld_q)) state_d = DONE;
         default: state_d = IDLE;
      endcase
      // Start is only honoured when no run is in flight, so the pipeline is empty here
      if (restart) begin
         state_d     = ISSUE;
         issue_now   = 1'b1;
         issue_idx_d = '0;
      end
   end

   // Core drive, tag shift, error bookkeeping and status outputs
   always_comb begin
      core_state_d = '0;
      core_key_d   = '0;
      if (issue_now) begin
         core_state_d = VEC_STATE[32'(issue_idx_d)*DATA_W +: DATA_W];
         core_key_d   = VEC_KEY[32'(issue_idx_d)*DATA_W +: DATA_W];
      end
      tag_vld_d = {tag_vld_q[LATENCY-1:0], issue_now};
      tag_idx_d = {tag_idx_q[LATENCY-1:0], issue_idx_d};

      err_count_d  = err_count_q;
      fail_index_d = fail_index_q;
      if (restart) begin
         err_count_d  = '0;
         fail_index_d = '0;
      end else if (mismatch) begin
         if (err_count_q == '0) fail_index_d = cmp_idx;
         if (err_count_q != '1) err_count_d  = err_count_q + 1'b1;
      end

      busy_d = (state_d == ISSUE) || (state_d == DRAIN);
      done_d = (state_d == DONE);
      pass_d = pass_q;
      if (restart)
         pass_d = 1'b0;
      else if ((state_q != DONE) && (state_d == DONE))
         pass_d = (err_count_d == '0);
   end

   // State and output registers, all cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         issue_idx_q  <= '0;
         core_state_q <= '0;
         core_key_q   <= '0;
         tag_vld_q    <= '0;
         tag_idx_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_index_q <= '0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         issue_idx_q  <= issue_idx_d;
         core_state_q <= core_state_d;
         core_key_q   <= core_key_d;
         tag_vld_q    <= tag_vld_d;
         tag_idx_q    <= tag_idx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         fail_index_q <= fail_index_d;
         err_count_q  <= err_count_d;
      end
   end

   assign bus.core_state = core_state_q;
   assign bus.core_key   = core_key_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.fail_index = fail_index_q;
   assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_aes_kat_bist.sv
// Directed bench for aes_kat_bist: three sequencers (plain, stop-on-fail with a short
// core, continuous) each fed by a table-lookup core model with a fault-injection mask.
module tb_aes_kat_bist;

   localparam logic [127:0] KS [5] = '{128'h3243f6a8885a308d313198a2e0370734,
      128'h00112233445566778899aabbccddeeff, 128'h0, 128'h0, 128'h1};
   localparam logic [127:0] KK [5] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h000102030405060708090a0b0c0d0e0f, 128'h0, 128'h1, 128'h0};
   localparam logic [127:0] KE [5] = '{128'h3925841d02dc09fbdc118597196a0b32,
      128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
      128'h0545aad56da2a97c3663d1432a3d1c84, 128'h58e2fccefa7e3061367f1d57a4e7455a};
   localparam logic [639:0] VS = {KS[4], KS[3], KS[2], KS[1], KS[0]};
   localparam logic [639:0] VK = {KK[4], KK[3], KK[2], KK[1], KK[0]};
   localparam logic [639:0] VE = {KE[4], KE[3], KE[2], KE[1], KE[0]};

   logic       clk;
   logic       rst;
   logic [4:0] fm_a, fm_b, fm_c;
   int         n_chk, n_fail, n;

   aes_kat_bist_if #(.DATA_W(128), .IDX_W(3), .ERR_W(8)) ia ();
   aes_kat_bist_if #(.DATA_W(128), .IDX_W(3), .ERR_W(8)) ib ();
   aes_kat_bist_if #(.DATA_W(128), .IDX_W(3), .ERR_W(8)) ic ();

   aes_kat_bist #(.DATA_W(128), .NUM_VEC(5), .IDX_W(3), .LATENCY(20), .VEC_STATE(VS),
      .VEC_KEY(VK), .VEC_EXP(VE), .STOP_ON_FAIL(1'b0), .CONTINUOUS(1'b0), .ERR_W(8))
      dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
   aes_kat_bist #(.DATA_W(128), .NUM_VEC(5), .IDX_W(3), .LATENCY(2), .VEC_STATE(VS),
      .VEC_KEY(VK), .VEC_EXP(VE), .STOP_ON_FAIL(1'b1), .CONTINUOUS(1'b0), .ERR_W(8))
      dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
   aes_kat_bist #(.DATA_W(128), .NUM_VEC(5), .IDX_W(3), .LATENCY(20), .VEC_STATE(VS),
      .VEC_KEY(VK), .VEC_EXP(VE), .STOP_ON_FAIL(1'b0), .CONTINUOUS(1'b1), .ERR_W(8))
      dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

   // Stand-in AES: only knows the five table pairs
   function automatic logic [127:0] aes_ref(input logic [127:0] s, input logic [127:0] k);
      aes_ref = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
      for (int i = 0; i < 5; i++)
         if (s == KS[i] && k == KK[i]) aes_ref = KE[i];
   endfunction

   // Flip bit 0 of the result belonging to any vector selected in the mask
   function automatic logic [127:0] fault(input logic [127:0] v, input logic [4:0] m);
      fault = v;
      for (int i = 0; i < 5; i++)
         if (m[i] && v == KE[i]) fault = v ^ 128'd1;
   endfunction

   // Core models: result of the entry driven after edge T is stable before edge T+LATENCY+1
   logic [127:0] pa [20];
   logic [127:0] pb [2];
   logic [127:0] pc [20];

   always @(posedge clk) begin
      pa[0] <= aes_ref(ia.core_state, ia.core_key);
      for (int i = 1; i < 20; i++) pa[i] <= pa[i-1];
   end
   always @(posedge clk) begin
      pb[0] <= aes_ref(ib.core_state, ib.core_key);
      pb[1] <= pb[0];
   end
   always @(posedge clk) begin
      pc[0] <= aes_ref(ic.core_state, ic.core_key);
      for (int i = 1; i < 20; i++) pc[i] <= pc[i-1];
   end

   assign ia.core_out = fault(pa[19], fm_a);
   assign ib.core_out = fault(pb[1], fm_b);
   assign ic.core_out = fault(pc[19], fm_c);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic get_done(input int s);
      case (s)
         0:       get_done = ia.done;
         1:       get_done = ib.done;
         default: get_done = ic.done;
      endcase
   endfunction

   // Edges until done is seen, bounded
   task automatic wait_done(input int s, input int lim, output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!get_done(s) && cnt < lim);
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b1;
      fm_a = '0; fm_b = '0; fm_c = '0;
      ia.start = 1'b0; ia.start_n_stop = 1'b0;
      ib.start = 1'b0; ib.start_n_stop = 1'b0;
      ic.start = 1'b0; ic.start_n_stop = 1'b0;
      repeat (2) tick();

      // Reset state
      chk("rst_state", ia.core_state, 128'd0);
      chk("rst_key",   ia.core_key,   128'd0);
      chk("rst_flags", 128'({ia.busy, ia.done, ia.pass}), 128'd0);
      chk("rst_fidx",  128'(ia.fail_index), 128'd0);
      chk("rst_err",   128'(ia.err_count),  128'd0);
      rst = 1'b0;
      tick();

      // Clean run: entry 0 driven on the ISSUE entry edge, done 26 edges later
      ia.start = 1'b1; tick(); ia.start = 1'b0;
      chk("t1_busy",  128'(ia.busy), 128'd1);
      chk("t1_st0",   ia.core_state, KS[0]);
      chk("t1_key0",  ia.core_key,   KK[0]);
      wait_done(0, 100, n);
      chk("t1_len",   128'(n), 128'd26);
      chk("t1_pass",  128'(ia.pass), 128'd1);
      chk("t1_err",   128'(ia.err_count), 128'd0);
      chk("t1_idle",  128'({ia.busy, ia.core_state != 128'd0}), 128'd0);
      tick();

      // Single-bit fault on vector 1
      fm_a = 5'b00010;
      ia.start = 1'b1; tick(); ia.start = 1'b0;
      chk("t2_donecl", 128'(ia.done), 128'd0);
      chk("t2_passcl", 128'(ia.pass), 128'd0);
      wait_done(0, 100, n);
      chk("t2_len",   128'(n), 128'd26);
      chk("t2_pass",  128'(ia.pass), 128'd0);
      chk("t2_fidx",  128'(ia.fail_index), 128'd1);
      chk("t2_err",   128'(ia.err_count),  128'd1);
      fm_a = '0;
      tick();

      // Stray starts sampled in ISSUE (edge +3) and DRAIN (edge +16) are ignored
      ia.start = 1'b1; tick(); ia.start = 1'b0;
      chk("t4_errcl", 128'(ia.err_count), 128'd0);
      n = 0;
      while (!ia.done && n < 100) begin
         ia.start = (n == 2 || n == 15);
         tick();
         n++;
      end
      ia.start = 1'b0;
      chk("t4_len",   128'(n), 128'd26);
      chk("t4_pass",  128'(ia.pass), 128'd1);
      repeat (3) tick();
      chk("t4_hold",  128'({ia.busy, ia.done}), 128'd1);

      // Async reset mid-DRAIN after two faulty compares
      fm_a = 5'b00110;
      ia.start = 1'b1; tick(); ia.start = 1'b0;
      repeat (23) tick();
      chk("t5_pre_err",  128'(ia.err_count),  128'd2);
      chk("t5_pre_fidx", 128'(ia.fail_index), 128'd1);
      chk("t5_pre_busy", 128'(ia.busy), 128'd1);
      #3 rst = 1'b1;
      #1;
      chk("t5_busy",  128'(ia.busy), 128'd0);
      chk("t5_err",   128'(ia.err_count),  128'd0);
      chk("t5_fidx",  128'(ia.fail_index), 128'd0);
      chk("t5_flags", 128'({ia.done, ia.pass}), 128'd0);
      fm_a = '0;
      tick();
      rst = 1'b0;
      tick();
      ia.start = 1'b1; tick(); ia.start = 1'b0;
      wait_done(0, 100, n);
      chk("t5_len",   128'(n), 128'd26);
      chk("t5_pass",  128'(ia.pass), 128'd1);

      // Stop-on-fail, every result corrupted, LATENCY=2: entries 0..2 issued, 3 never
      fm_b = 5'b11111;
      ib.start = 1'b1; tick(); ib.start = 1'b0;
      repeat (3) tick();
      chk("t3_abort", ib.core_state, 128'd0);
      chk("t3_busy",  128'(ib.busy), 128'd1);
      wait_done(1, 100, n);
      chk("t3_len",   128'(n + 3), 128'd6);
      chk("t3_err",   128'(ib.err_count),  128'd3);
      chk("t3_fidx",  128'(ib.fail_index), 128'd0);
      chk("t3_pass",  128'(ib.pass), 128'd0);
      fm_b = '0;

      // Continuous: three back-to-back runs, then drop the enable and stay in DONE
      ic.start_n_stop = 1'b1;
      ic.start = 1'b1; tick(); ic.start = 1'b0;
      wait_done(2, 100, n);
      chk("t6_len0",  128'(n), 128'd26);
      chk("t6_pass0", 128'(ic.pass), 128'd1);
      for (int r = 0; r < 2; r++) begin
         tick();
         chk("t6_restart", 128'({ic.busy, ic.done}), 128'd2);
         chk("t6_st0",     ic.core_state, KS[0]);
         wait_done(2, 100, n);
         chk("t6_len",  128'(n + 1), 128'd27);
         chk("t6_pass", 128'(ic.pass), 128'd1);
      end
      ic.start_n_stop = 1'b0;
      repeat (4) tick();
      chk("t6_stop",  128'({ic.busy, ic.done}), 128'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
